// File: rtl/demux_dispatch_ctrl.sv
// demux_dispatch_ctrl: round-robin dispatcher that steers one valid/ready word
// stream, in bursts of up to BURST words, to one of four output channels through
// a one-entry output register. The register is drained before the grant moves on.
// Optional build macro: DEMUX_DISPATCH_STATS_EN adds four 16-bit per-channel
// output handshake counters that are read back through stat_sel/stat_cnt.
module demux_dispatch_ctrl #(
    parameter int WIDTH = 8,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    input  logic [3:0]       ch_en,
    output logic [WIDTH-1:0] out_data,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [1:0]       sel,
    output logic             busy
`ifdef DEMUX_DISPATCH_STATS_EN
    ,
    input  logic [1:0]       stat_sel,
    output logic [15:0]      stat_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t     state;
    logic [1:0] ptr;
    logic [7:0] cnt;
    logic       full;

    logic       grant_valid;
    logic [1:0] grant_idx;
    logic       accept;
    logic       sel_ready;
    logic       burst_done;
    logic       drained;
    logic [8:0] cnt_next;

    // Round-robin search starting just after the last grant; the last-granted
    // channel is tried last so a lone enabled channel is re-granted.
    function automatic logic [2:0] pick(input logic [3:0] en, input logic [1:0] last);
        logic [1:0] idx;
        pick = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (en[idx]) begin
                pick = {1'b1, idx};
            end
        end
    endfunction

    // Arbitration, handshake and burst-end decode for the current cycle.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = 2'd0;
        {grant_valid, grant_idx} = pick(ch_en, ptr);
        sel_ready  = out_ready[sel];
        in_ready   = (state == XFER) && (!full || sel_ready);
        accept     = in_valid && in_ready;
        cnt_next   = {1'b0, cnt} + 9'd1;
        burst_done = accept && ((cnt_next == 9'(BURST)) || in_last);
        drained    = !full || sel_ready;
    end

    // Output views are taken straight from the state registers.
    always_comb begin
        out_valid = full ? (4'b0001 << sel) : 4'b0000;
        busy      = (state != IDLE);
    end

    // Dispatcher FSM together with the output register, grant pointer and burst count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 2'd3;
            cnt      <= 8'd0;
            full     <= 1'b0;
            sel      <= 2'd0;
            out_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        sel   <= grant_idx;
                        ptr   <= grant_idx;
                        cnt   <= 8'd0;
                        state <= XFER;
                    end
                end
                XFER: begin
                    if (accept) begin
                        out_data <= in_data;
                        full     <= 1'b1;
                        cnt      <= cnt_next[7:0];
                    end else if (full && sel_ready) begin
                        full <= 1'b0;
                    end
                    if (burst_done || !ch_en[sel]) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drained) begin
                        full <= 1'b0;
                        if (grant_valid) begin
                            sel   <= grant_idx;
                            ptr   <= grant_idx;
                            cnt   <= 8'd0;
                            state <= XFER;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef DEMUX_DISPATCH_STATS_EN
    logic [15:0] stat_count [4];

    // Per-channel count of completed output handshakes, wrapping at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                stat_count[i] <= 16'd0;
            end
        end else if (full && sel_ready) begin
            stat_count[sel] <= stat_count[sel] + 16'd1;
        end
    end

    assign stat_cnt = stat_count[stat_sel];
`else
    // No statistics hardware in this build.
`endif

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// tb_demux_dispatch_ctrl: table-driven directed bench for demux_dispatch_ctrl
// (WIDTH=8, BURST=4), with a hand-written reset-during-burst sequence.
module tb_demux_dispatch_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [3:0] ch_en;
    logic [7:0] out_data;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [1:0] sel;
    logic       busy;
`ifdef DEMUX_DISPATCH_STATS_EN
    logic [1:0]  stat_sel;
    logic [15:0] stat_cnt;
`endif

    int checks;
    int failures;

    typedef struct {
        logic       rst;
        logic [3:0] ch_en;
        logic       in_valid;
        logic [7:0] in_data;
        logic       in_last;
        logic [3:0] out_ready;
        logic       e_in_ready;
        logic [3:0] e_out_valid;
        logic [1:0] e_sel;
        logic       e_busy;
        logic       chk_data;
        logic [7:0] e_out_data;
    } vec_t;

    vec_t vecs[$];

    demux_dispatch_ctrl #(.WIDTH(8), .BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .ch_en     (ch_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel       (sel),
        .busy      (busy)
`ifdef DEMUX_DISPATCH_STATS_EN
        ,
        .stat_sel  (stat_sel),
        .stat_cnt  (stat_cnt)
`endif
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic add(input logic r, input logic [3:0] en, input logic iv, input logic [7:0] id,
                       input logic il, input logic [3:0] ordy, input logic eir, input logic [3:0] eov,
                       input logic [1:0] esel, input logic ebusy, input logic cd, input logic [7:0] eod);
        vec_t v;
        v.rst = r; v.ch_en = en; v.in_valid = iv; v.in_data = id; v.in_last = il;
        v.out_ready = ordy; v.e_in_ready = eir; v.e_out_valid = eov; v.e_sel = esel;
        v.e_busy = ebusy; v.chk_data = cd; v.e_out_data = eod;
        vecs.push_back(v);
    endtask

    task automatic checkField(input string name, input int idx, input logic [15:0] actual,
                              input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, idx, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst       = v.rst;
        ch_en     = v.ch_en;
        in_valid  = v.in_valid;
        in_data   = v.in_data;
        in_last   = v.in_last;
        out_ready = v.out_ready;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        checkField("in_ready", idx, {15'd0, in_ready}, {15'd0, v.e_in_ready});
        checkField("out_valid", idx, {12'd0, out_valid}, {12'd0, v.e_out_valid});
        checkField("sel", idx, {14'd0, sel}, {14'd0, v.e_sel});
        checkField("busy", idx, {15'd0, busy}, {15'd0, v.e_busy});
        if (v.chk_data) begin
            checkField("out_data", idx, {8'd0, out_data}, {8'd0, v.e_out_data});
        end
    endtask

    // One step: drive at the falling edge, check 1 unit later, the rising edge follows.
    task automatic step(input vec_t v, input int idx);
        @(negedge clk);
        applyStimulus(v);
        #1;
        checkOutput(v, idx);
    endtask

    initial begin
        vec_t v;
        int   ch;
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        ch_en     = 4'b0000;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 4'b0000;
`ifdef DEMUX_DISPATCH_STATS_EN
        stat_sel  = 2'd1;
`endif

        // Reset values, then idle with no channel enabled.
        add(1, 4'h0, 0, 8'h00, 0, 4'hF, 0, 4'h0, 0, 0, 1, 8'h00);
        add(1, 4'h0, 0, 8'h00, 0, 4'hF, 0, 4'h0, 0, 0, 1, 8'h00);
        for (int i = 0; i < 10; i++) begin
            add(0, 4'h0, 0, 8'h00, 0, 4'hF, 0, 4'h0, 0, 0, 1, 8'h00);
        end

        // Full round-robin over all four channels, ending on channel 0 again.
        add(0, 4'hF, 1, 8'h00, 0, 4'hF, 0, 4'h0, 0, 0, 1, 8'h00);
        for (int b = 0; b < 5; b++) begin
            ch = b % 4;
            for (int j = 0; j < 4; j++) begin
                add(0, 4'hF, 1, 8'(4 * b + j), 0, 4'hF, 1, (j == 0) ? 4'h0 : 4'(1 << ch),
                    2'(ch), 1, 1, (b == 0 && j == 0) ? 8'h00 : 8'(4 * b + j - 1));
            end
            add(0, (b == 4) ? 4'h0 : 4'hF, 1, 8'(4 * b + 4), 0, 4'hF, 0, 4'(1 << ch),
                2'(ch), 1, 1, 8'(4 * b + 3));
        end
        add(0, 4'h0, 0, 8'h00, 0, 4'hF, 0, 4'h0, 0, 0, 1, 8'h13);

        // Early end with in_last on channel 0, next grant is channel 1.
        add(0, 4'h1, 0, 8'h00, 0, 4'hF, 0, 4'h0, 0, 0, 1, 8'h13);
        add(0, 4'h3, 1, 8'hA0, 0, 4'hF, 1, 4'h0, 0, 1, 1, 8'h13);
        add(0, 4'h3, 1, 8'hA1, 1, 4'hF, 1, 4'h1, 0, 1, 1, 8'hA0);
        add(0, 4'h3, 1, 8'hA2, 0, 4'hF, 0, 4'h1, 0, 1, 1, 8'hA1);
        add(0, 4'h0, 0, 8'h00, 0, 4'hF, 1, 4'h0, 1, 1, 1, 8'hA1);
        add(0, 4'h0, 0, 8'h00, 0, 4'hF, 0, 4'h0, 1, 1, 1, 8'hA1);
        add(0, 4'h0, 0, 8'h00, 0, 4'hF, 0, 4'h0, 1, 0, 1, 8'hA1);

        // Consumer backpressure while draining channel 0.
        add(0, 4'h1, 0, 8'h00, 0, 4'hF, 0, 4'h0, 1, 0, 1, 8'hA1);
        add(0, 4'h1, 1, 8'hB0, 1, 4'hF, 1, 4'h0, 0, 1, 1, 8'hA1);
        for (int i = 0; i < 5; i++) begin
            add(0, 4'h3, 1, 8'hB1, 0, 4'h0, 0, 4'h1, 0, 1, 1, 8'hB0);
        end
        add(0, 4'h3, 1, 8'hB1, 0, 4'hF, 0, 4'h1, 0, 1, 1, 8'hB0);
        add(0, 4'hA, 0, 8'h00, 0, 4'hF, 1, 4'h0, 1, 1, 1, 8'hB0);

        // Masked channels 1 and 3, stall on full register, disable mid-burst.
        add(0, 4'hA, 1, 8'hC0, 0, 4'hF, 1, 4'h0, 1, 1, 1, 8'hB0);
        add(0, 4'hA, 1, 8'hC1, 0, 4'hD, 0, 4'h2, 1, 1, 1, 8'hC0);
        add(0, 4'hA, 1, 8'hC1, 1, 4'hF, 1, 4'h2, 1, 1, 1, 8'hC0);
        add(0, 4'hA, 0, 8'h00, 0, 4'hF, 0, 4'h2, 1, 1, 1, 8'hC1);
        add(0, 4'hA, 1, 8'hD0, 1, 4'hF, 1, 4'h0, 3, 1, 1, 8'hC1);
        add(0, 4'hA, 0, 8'h00, 0, 4'hF, 0, 4'h8, 3, 1, 1, 8'hD0);
        add(0, 4'hA, 1, 8'hE0, 0, 4'hF, 1, 4'h0, 1, 1, 1, 8'hD0);
        add(0, 4'hA, 1, 8'hE1, 0, 4'hF, 1, 4'h2, 1, 1, 1, 8'hE0);
        add(0, 4'h8, 0, 8'h00, 0, 4'hF, 1, 4'h2, 1, 1, 1, 8'hE1);
        add(0, 4'h8, 0, 8'h00, 0, 4'hF, 0, 4'h0, 1, 1, 1, 8'hE1);
        add(0, 4'h8, 0, 8'h00, 0, 4'hF, 1, 4'h0, 3, 1, 1, 8'hE1);

        foreach (vecs[i]) begin
            step(vecs[i], i);
        end

        // Reset while channel 3 holds a word; first grant afterwards is channel 0.
        v = vecs[vecs.size() - 1];
        v.in_valid = 1; v.in_data = 8'hF0;
        v.e_in_ready = 1; v.e_out_valid = 4'h0; v.e_sel = 3; v.e_busy = 1; v.e_out_data = 8'hE1;
        step(v, 1000);
        v.rst = 1; v.ch_en = 4'hF; v.in_valid = 0;
        v.e_in_ready = 1; v.e_out_valid = 4'h8; v.e_sel = 3; v.e_busy = 1; v.e_out_data = 8'hF0;
        step(v, 1001);
        v.rst = 0;
        v.e_in_ready = 0; v.e_out_valid = 4'h0; v.e_sel = 0; v.e_busy = 0; v.e_out_data = 8'h00;
        step(v, 1002);
        v.e_in_ready = 1; v.e_out_valid = 4'h0; v.e_sel = 0; v.e_busy = 1; v.e_out_data = 8'h00;
        step(v, 1003);
`ifdef DEMUX_DISPATCH_STATS_EN
        stat_sel = 2'd1;
        #1;
        checkField("stat_cnt1_after_reset", 1003, stat_cnt, 16'd0);
        v.in_valid = 1; v.in_data = 8'h55; v.in_last = 1;
        step(v, 1004);
        v.in_valid = 0; v.in_last = 0;
        v.e_in_ready = 0; v.e_out_valid = 4'h1; v.e_sel = 0; v.e_busy = 1; v.e_out_data = 8'h55;
        step(v, 1005);
        v.ch_en = 4'h0;
        @(negedge clk);
        stat_sel = 2'd0;
        #1;
        checkField("stat_cnt0_one_word", 1006, stat_cnt, 16'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux_dispatch_ctrl.md
# demux_dispatch_ctrl

Round-robin dispatcher that sequences the 1-to-4 demultiplexer datapath. It accepts a single valid/ready word stream and steers it, in bursts of up to BURST words, to one of four output channels at a time. Before moving to the next enabled channel it drains its output register. It sits between a shared upstream source and four downstream consumers, and owns the demux select.

## Interface
Parameters:
- WIDTH, 8, data word width in bits.
- BURST, 4, maximum words accepted per grant (legal range 1..255).

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Rst  input  1  reset, synchronous, active-high.
- In_Data  input  WIDTH  upstream word.
- In_Valid  input  1  upstream word valid.
- In_Last  input  1  qualifies In_Data; ends the current burst early.
- In_Ready  output  1  dispatcher accepts In_Data this cycle (combinational).
- Ch_En  input  4  per-channel enable; bit i set means channel i is eligible.
- Out_Data  output  WIDTH  registered word, shared by all channels.
- Out_Valid  output  4  one-hot valid; bit Sel is set while the register is full.
- Out_Ready  input  4  per-channel consumer ready.
- Sel  output  2  currently granted channel (demux select).
- Busy  output  1  high in XFER or DRAIN.

## Operation
The dispatcher uses three states: IDLE, XFER and DRAIN. It holds a 2-bit last-grant pointer Ptr (reset value 3), a burst counter Cnt (reset value 0) and a one-entry output register.

- **Arbitration.** The next channel is the first i with Ch_En[i]=1, searching Ptr+1, Ptr+2, Ptr+3, Ptr (mod 4). Out_Ready is not considered. On a grant, Sel and Ptr are set to i and Cnt is cleared.
- **IDLE.** In_Ready=0. If Ch_En≠0, grant and go to XFER next cycle; otherwise stay in IDLE.
- **XFER.**
  - In_Ready = ~Full | Out_Ready[Sel].
  - Accept: In_Valid & In_Ready. The word is loaded into the register, Full=1 and Cnt increments.
  - Output: Out_Ready[Sel] & Full with no accept clears Full.
  - The burst ends on the accept where Cnt+1==BURST or In_Last=1; the next state is DRAIN.
  - If Ch_En[Sel] drops in XFER, go to DRAIN next cycle, whether or not a word was accepted that cycle. Any accept in that cycle is still valid.
- **DRAIN.** In_Ready=0. When Full=0, or Full=1 with Out_Ready[Sel]=1, the register is empty at the end of the cycle. At that point the dispatcher arbitrates using the Ch_En sampled that cycle: it goes to XFER with the new grant, or to IDLE if Ch_En=0. Otherwise it stays in DRAIN.
- **Round-robin repeat.** If only the current channel is enabled, arbitration re-grants the same channel.
- **Sel stability.** Sel changes only on the DRAIN→XFER or IDLE→XFER edge, never while Out_Valid≠0.
- **Output valid.** Out_Valid = Full ? (1<<Sel) : 0. Out_Data holds its value when not loading.
- **Reset.** Rst at any time, including mid-burst with Full=1, discards the buffered word and forces:
  - state IDLE, Ptr=3, Cnt=0, Full=0;
  - outputs Out_Data=0, Out_Valid=0, Sel=0, Busy=0, In_Ready=0.

## Timing
- In_Data to Out_Data/Out_Valid latency is 1 cycle.
- Throughput within a burst is 1 word per cycle while Out_Ready[Sel]=1.
- The channel switch costs at least 1 cycle in DRAIN with In_Ready=0, plus any stall while waiting for the consumer.
- IDLE→XFER takes 1 cycle after Ch_En becomes nonzero.
- In the first XFER cycle In_Ready is high (register empty).
- In_Ready depends combinationally on Out_Ready, the state and Full. It does not depend on In_Valid.

## Configuration
- DEMUX_DISPATCH_STATS_EN defined:
  - Adds input Stat_Sel[1:0] and output Stat_Cnt[15:0].
  - There are four 16-bit counters. Counter Sel increments on every output handshake (Full & Out_Ready[Sel]) and wraps from 0xFFFF to 0.
  - Stat_Cnt = counter[Stat_Sel], combinational.
  - The counters reset to 0 on Rst.
- DEMUX_DISPATCH_STATS_EN undefined: the stats ports and counters are absent. All other behaviour is identical.

## Test plan
- **Reset values.** Rst held 2 cycles, then Ch_En=4'b0000 → Busy=0, Sel=0, Out_Valid=0, In_Ready=0 for 10 cycles.
- **Full round-robin.** BURST=4, Ch_En=4'b1111, In_Valid constant, Out_Ready=4'b1111, data 0x00,0x01,… → words 0x00–0x03 on channel 0, 0x04–0x07 on channel 1, and so on. Exactly one In_Ready=0 cycle between bursts; channel order 0,1,2,3,0.
- **Early end with In_Last.** In_Last on the 2nd word of channel 0's burst → only 2 words reach Out_Valid=4'b0001, then the next grant is channel 1.
- **Backpressure in DRAIN.** Out_Ready[Sel]=0 for 5 cycles after the last burst word → Out_Valid stays 4'b0001, Sel stays 0, DRAIN persists. The switch occurs the cycle after Out_Ready returns.
- **Masked channels and disable mid-burst.** Ch_En=4'b1010 → grants alternate 1,3,1. Clearing Ch_En[1] after its 2nd accept → burst ends and channel 3 is granted next.
- **Reset mid-burst.** Rst asserted with Full=1 → next cycle Out_Valid=0, IDLE, Ptr=3; the first grant after release is channel 0. With DEMUX_DISPATCH_STATS_EN, counter 1 reads 0 after reset.
